uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning byte width written to UART TX FIFO.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning max bytes per grant before forced rotation (1..255).
REQ-004 SHALL have port PCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port PRESETn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ch_enable  input  NUM_REQ  per-requester enable mask from control register.
REQ-007 SHALL have port req_valid  input  NUM_REQ  requester byte valid.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_last  input  NUM_REQ  marks final byte of requester packet.
REQ-010 SHALL have port req_ready  output  NUM_REQ  byte accepted when valid&ready.
REQ-011 SHALL have port fifo_full  input  1  TX FIFO full flag.
REQ-012 SHALL have port fifo_wr_en  output  1  TX FIFO write strobe.
REQ-013 SHALL have port fifo_wr_data  output  DATA_WIDTH  TX FIFO write data.
REQ-014 SHALL have port grant_id  output  clog2(NUM_REQ)  index of current owner (valid when busy).
REQ-015 SHALL have port busy  output  1  high while a requester holds the grant.

Function
REQ-016 SHALL implement FSM states IDLE and LOCKED.
REQ-017 IDLE: eligible = req_valid & ch_enable; if nonzero, SHALL register winner into grant_id, clear burst counter, go LOCKED next cycle (one-cycle arbitration latency); no transfers in IDLE.
REQ-018 Winner SHALL be first eligible index searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-019 LOCKED: req_ready[grant_id] = ~fifo_full & ch_enable[grant_id]; all other req_ready bits SHALL be 0.
REQ-020 fifo_wr_en SHALL equal req_valid[grant_id] & req_ready[grant_id] combinationally; fifo_wr_data = req_data of grant_id; no added latency.
REQ-021 Each transfer SHALL increment burst counter (width clog2(MAX_BURST+1)).
REQ-022 LOCKED SHALL exit to IDLE after a transfer with req_last high, or the transfer making burst count equal MAX_BURST, or any cycle with ch_enable[grant_id] low (no transfer that cycle).
REQ-023 On exit, rr_ptr SHALL become grant_id+1 modulo NUM_REQ.
REQ-024 fifo_full high SHALL stall the owner indefinitely without losing grant; req_valid deasserted mid-packet SHALL keep grant.
REQ-025 fifo_wr_en SHALL never assert while fifo_full is high.
REQ-026 Simultaneous last and MAX_BURST on same transfer SHALL cause one exit, rr_ptr advanced once.
REQ-027 busy SHALL be 1 exactly in LOCKED.

Reset
REQ-028 PRESETn low at a PCLK edge SHALL force IDLE, rr_ptr=0, grant_id=0, burst counter=0, including mid-packet; partial packet abandoned.
REQ-029 During reset, req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.

Structure
REQ-030 Shared package uart_pkg SHALL hold FSM state encoding and default NUM_REQ/MAX_BURST constants.
REQ-031 Round-robin search SHALL be sub-module uart_rr_pick (inputs eligible, rr_ptr; outputs found, index), purely combinational.

Verification
REQ-032 Single requester 0, 3-byte packet 0x41,0x42,0x43 last on 0x43 -> busy one cycle after valid, three consecutive fifo_wr_en, IDLE after, rr_ptr=1.
REQ-033 Requesters 0..3 all valid continuously, 1-byte packets -> grants order 0,1,2,3,0; each grant 2 cycles (IDLE+LOCKED).
REQ-034 Requester 2 streams 40 bytes without last, MAX_BURST=16 -> exactly 16 writes per grant, rotation to requester 3 when valid.
REQ-035 fifo_full high 5 cycles mid-packet -> req_ready=0, fifo_wr_en=0 those cycles, grant_id unchanged, no byte lost or duplicated.
REQ-036 ch_enable[1] cleared while 1 LOCKED -> IDLE next cycle, no write that cycle; ch_enable=4'b0000 with all valid -> never busy.
REQ-037 PRESETn low one cycle mid-packet -> all outputs 0, next arbitration starts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and FSM encoding for the UART TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin search; first eligible index at or
//                above rr_ptr, wrapping from NUM_REQ-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest eligible wins.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (eligible[w_cand]) begin
                found = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin packet arbiter feeding a UART TX FIFO, with a
//                per-grant burst limit and per-channel enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              ch_enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [IDX_W-1:0]                grant_id,
    output logic                            busy
);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]      burst_q;
    logic [CNT_W-1:0]      burst_d;
    logic                  busy_q;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_locked;
    logic                  w_own_en;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_own_ready;
    logic                  w_xfer;
    logic                  w_burst_max;
    logic                  w_exit;

    assign w_eligible = req_valid & ch_enable;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .eligible (w_eligible),
        .rr_ptr   (rr_ptr_q),
        .found    (w_found),
        .index    (w_pick)
    );

    // Owner-side view of the requester bus, selected by the current grant.
    always_comb begin
        w_own_en    = 1'b0;
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                w_own_en    = ch_enable[i];
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating with PRESETn keeps every handshake quiet during a reset cycle,
    // even if the state register still holds LOCKED from before.
    assign w_locked    = (state_q == ST_LOCKED) && PRESETn;
    assign w_own_ready = w_locked & w_own_en & ~fifo_full;
    assign w_xfer      = w_own_ready & w_own_valid;
    assign burst_d     = burst_q + CNT_W'(1);
    assign w_burst_max = (burst_d == CNT_W'(MAX_BURST));
    assign w_exit      = w_locked & (~w_own_en | (w_xfer & (w_own_last | w_burst_max)));
    assign rr_ptr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_own_ready) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign fifo_wr_en   = w_xfer;
    assign fifo_wr_data = w_locked ? w_own_data : '0;
    assign grant_id     = grant_q;
    assign busy         = busy_q & PRESETn;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        grant_q <= w_pick;
                        burst_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        burst_q <= burst_d;
                    end
                    if (w_exit) begin
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter against a
//                transaction-level model of owner, pointer and burst count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    en, vld, last, rdy;
    logic [N*DW-1:0] data;
    logic            full, wr, busy;
    logic [DW-1:0]   wdata;
    logic [1:0]      gid;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .PCLK         (clk),
        .PRESETn      (rstn),
        .ch_enable    (en),
        .req_valid    (vld),
        .req_data     (data),
        .req_last     (last),
        .req_ready    (rdy),
        .fifo_full    (full),
        .fifo_wr_en   (wr),
        .fifo_wr_data (wdata),
        .grant_id     (gid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: who owns the FIFO, where the next search starts, bytes this grant.
    bit m_busy, n_busy, m_sync;
    int m_g, m_ptr, m_cnt, n_g, n_ptr, n_cnt;
    logic [N-1:0]  e_rdy;
    logic          e_wr, e_busy;
    logic [DW-1:0] e_data;

    // Packet sources
    int       s_left[N];
    bit       s_nolast[N], s_hold[N], s_refill[N];
    bit [7:0] s_byte[N];
    bit       rnd_mode;

    int obs_wr, run, max_run, busy_seen;
    bit prev_busy;
    int glog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            vld[i]            = (s_left[i] > 0) && !s_hold[i];
            last[i]           = !s_nolast[i] && (s_left[i] == 1);
            data[i*DW +: DW]  = s_byte[i];
        end
    endtask

    task automatic model_eval();
        int  idx;
        bit  found;
        e_rdy = '0; e_wr = 1'b0; e_data = '0; e_busy = 1'b0;
        n_busy = m_busy; n_g = m_g; n_ptr = m_ptr; n_cnt = m_cnt;
        if (!rstn) begin
            n_busy = 0; n_g = 0; n_ptr = 0; n_cnt = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && vld[idx] && en[idx]) begin
                    found = 1; n_busy = 1; n_g = idx; n_cnt = 0;
                end
            end
        end else begin
            e_busy = 1'b1;
            e_data = data[m_g*DW +: DW];
            if (!en[m_g]) begin
                n_busy = 0; n_ptr = (m_g + 1) % N;
            end else if (!full) begin
                e_rdy[m_g] = 1'b1;
                if (vld[m_g]) begin
                    e_wr  = 1'b1;
                    n_cnt = m_cnt + 1;
                    if (last[m_g] || n_cnt == MB) begin
                        n_busy = 0; n_ptr = (m_g + 1) % N;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        if (!rnd_mode) drive_src();
        @(negedge clk);
        model_eval();
        chk("busy", busy, e_busy);
        chk("req_ready", rdy, e_rdy);
        chk("fifo_wr_en", wr, e_wr);
        if (e_busy || !rstn) chk("fifo_wr_data", wdata, e_data);
        if (m_sync) chk("grant_id", gid, m_g);
        obs_wr += int'(wr);
        if (busy) begin
            busy_seen++;
            if (wr) run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (busy && !prev_busy) glog.push_back(int'(gid));
        prev_busy = busy;
        @(posedge clk);
        #1;
        if (!rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (e_rdy[i] && vld[i]) begin
                    s_left[i]--;
                    s_byte[i]++;
                    if (s_left[i] == 0 && s_refill[i]) s_left[i] = 1;
                end
            end
        end
        m_busy = n_busy; m_g = n_g; m_ptr = n_ptr; m_cnt = n_cnt;
        if (!rstn) m_sync = 1;
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) begin
            s_left[i] = 0; s_nolast[i] = 0; s_hold[i] = 0; s_refill[i] = 0;
            s_byte[i] = 8'(8'h10 * i);
        end
        full = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        obs_wr = 0; run = 0; max_run = 0; busy_seen = 0;
        glog.delete();
    endtask

    int w0;
    bit done;

    initial begin
        rnd_mode = 0; m_sync = 0; m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
        prev_busy = 0;
        en = '0; vld = '0; last = '0; data = '0; full = 1'b0; rstn = 1'b0;
        tick();
        reset_dut();
        en = 4'hF;

        // Single 3-byte packet from requester 0
        s_left[0] = 3; s_byte[0] = 8'h41;
        repeat (6) tick();
        chk("pkt3_writes", obs_wr, 3);
        s_left[0] = 1; s_left[1] = 1;
        glog.delete();
        repeat (2) tick();
        chk("ptr_after_pkt_n", glog.size(), 1);
        if (glog.size() > 0) chk("ptr_after_pkt_id", glog[0], 1);

        // All four requesters with back-to-back 1-byte packets
        reset_dut();
        for (int i = 0; i < N; i++) begin
            s_left[i] = 1; s_refill[i] = 1;
        end
        repeat (10) tick();
        chk("rr_grants_n", glog.size(), 5);
        if (glog.size() >= 5) begin
            chk("rr_g0", glog[0], 0);
            chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 2);
            chk("rr_g3", glog[3], 3);
            chk("rr_g4", glog[4], 0);
        end

        // Burst limit: 40 bytes without last from requester 2
        reset_dut();
        s_left[2] = 40; s_nolast[2] = 1; s_left[3] = 2;
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            tick();
            done = (s_left[2] == 0) && (s_left[3] == 0);
        end
        chk("burst_done", done, 1);
        chk("burst_writes", obs_wr, 42);
        chk("burst_max_run", max_run, MB);

        // FIFO full stall and valid gap mid-packet
        reset_dut();
        s_left[1] = 8;
        repeat (3) tick();
        full = 1'b1;
        w0 = obs_wr;
        repeat (5) tick();
        chk("full_no_write", obs_wr - w0, 0);
        full = 1'b0;
        s_hold[1] = 1;
        repeat (2) tick();
        s_hold[1] = 0;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            tick();
            done = (s_left[1] == 0);
        end
        chk("full_done", done, 1);
        chk("full_writes", obs_wr, 8);

        // Channel disable while owning
        reset_dut();
        s_left[1] = 10;
        repeat (3) tick();
        en = 4'b1101;
        w0 = obs_wr;
        tick();
        chk("dis_no_write", obs_wr - w0, 0);
        repeat (2) tick();
        en = 4'b0000;
        reset_dut();
        for (int i = 0; i < N; i++) begin
            s_left[i] = 1; s_refill[i] = 1;
        end
        repeat (20) tick();
        chk("all_disabled_busy", busy_seen, 0);

        // Reset mid-packet restarts arbitration at requester 0
        en = 4'hF;
        reset_dut();
        s_left[3] = 10;
        repeat (4) tick();
        s_left[0] = 5; s_left[2] = 5;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        glog.delete();
        repeat (2) tick();
        chk("post_reset_n", glog.size(), 1);
        if (glog.size() > 0) chk("post_reset_id", glog[0], 0);

        // Randomized traffic
        rnd_mode = 1;
        for (int t = 0; t < 2000; t++) begin
            rstn = ($urandom_range(0, 63) != 0);
            en   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            vld  = 4'($urandom);
            for (int i = 0; i < N; i++) last[i] = ($urandom_range(0, 5) == 0);
            full = ($urandom_range(0, 3) == 0);
            data = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
